// File: rtl/pixel_combinator_if.sv
// Queue-side and stream-side signals of the pixel_combinator.
// The master modport is the combinator; the slave modport is the queues plus the downstream sink.
interface pixel_combinator_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 10,
    parameter int RBG_SIZE   = 24
);
    logic [NUM_QUEUES-1:0]          match_i;
    logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i;
    logic [DATA_WIDTH-1:0]          xpixel_check_o;
    logic [DATA_WIDTH-1:0]          ypixel_check_o;
    logic [NUM_QUEUES-1:0]          pop_o;
    logic [RBG_SIZE-1:0]            colour_o;
    logic                           valid_o;
    logic                           ready_i;
    logic                           sof_o;
    logic                           eol_o;

    modport master (
        input  match_i, colour_i, ready_i,
        output xpixel_check_o, ypixel_check_o, pop_o, colour_o, valid_o, sof_o, eol_o
    );

    modport slave (
        output match_i, colour_i, ready_i,
        input  xpixel_check_o, ypixel_check_o, pop_o, colour_o, valid_o, sof_o, eol_o
    );
endinterface

// File: rtl/pixel_combinator.sv
// Raster-order scheduler: re-serialises per-engine queue heads into a left-to-right, top-to-bottom stream.
// Optional SEEK watchdog enabled by defining COMBINATOR_TIMEOUT_EN.
module pixel_combinator #(
    parameter int NUM_QUEUES     = 4,
    parameter int DATA_WIDTH     = 10,
    parameter int RBG_SIZE       = 24,
    parameter int X_SIZE         = 640,
    parameter int Y_SIZE         = 480,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy_o,
    output logic                  multi_match_o,
    output logic                  timeout_o,
    pixel_combinator_if.master    bus
);

    typedef enum logic [1:0] {IDLE, SEEK, OUT} state_t;

    localparam logic [DATA_WIDTH-1:0] X_LAST    = DATA_WIDTH'(X_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST    = DATA_WIDTH'(Y_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] COORD_ONE = 1;
    localparam logic [NUM_QUEUES-1:0] MATCH_ONE = 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q, y_q;
    logic [RBG_SIZE-1:0]   colour_q;
    logic [NUM_QUEUES-1:0] pop_q;
    logic                  multi_q;

    logic                  any_match, multi, handshake, x_last, y_last;
    logic [NUM_QUEUES-1:0] sel_onehot;
    logic [RBG_SIZE-1:0]   sel_colour;
    logic                  take, substitute, to_hit;

    // Lowest-index match wins: the descending loop lets the last hit overwrite earlier ones.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any_match  = |bus.match_i;
        multi      = (bus.match_i & (bus.match_i - MATCH_ONE)) != '0;
        sel_onehot = '0;
        sel_colour = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (bus.match_i[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_colour    = bus.colour_i[i*RBG_SIZE +: RBG_SIZE];
            end
        end
    end

    assign handshake = (state_q == OUT) && bus.ready_i;
    assign x_last    = (x_q == X_LAST);
    assign y_last    = (y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        substitute = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = SEEK;
            SEEK: begin
                if (any_match) begin
                    take    = 1'b1;
                    state_d = OUT;
                end else if (to_hit) begin
                    substitute = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: if (handshake) state_d = (x_last && y_last) ? IDLE : SEEK;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: every register here is control or datapath state and is reset; there is no storage array to exclude.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            pop_q    <= '0;
            multi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pop_q   <= take ? sel_onehot : '0;
            multi_q <= take & multi;
            if (take)            colour_q <= sel_colour;
            else if (substitute) colour_q <= '0;
            if (handshake) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + COORD_ONE;
                end else begin
                    x_q <= x_q + COORD_ONE;
                end
            end
        end
    end

`ifdef COMBINATOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = 1;

    logic [TW-1:0] to_cnt;
    logic          timeout_q;

    // The counter idles at zero outside SEEK, so it restarts on every SEEK entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt <= (state_q == SEEK && state_d == SEEK) ? to_cnt + TO_ONE : '0;
            if (substitute) timeout_q <= 1'b1;
        end
    end

    assign to_hit    = (state_q == SEEK) && (to_cnt == TO_LAST);
    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign busy_o             = (state_q != IDLE);
    assign multi_match_o      = multi_q;
    assign bus.xpixel_check_o = x_q;
    assign bus.ypixel_check_o = y_q;
    assign bus.pop_o          = pop_q;
    assign bus.colour_o       = colour_q;
    assign bus.valid_o        = (state_q == OUT);
    assign bus.sof_o          = bus.valid_o && (x_q == '0) && (y_q == '0);
    assign bus.eol_o          = bus.valid_o && x_last;

endmodule

// File: tb/tb_pixel_combinator.sv
// Directed self-checking bench for pixel_combinator on a 4x2 frame with four queues.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pixel_combinator;

    localparam int NQ = 4;
    localparam int DW = 10;
    localparam int CW = 24;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, multi_match, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_combinator_if #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RBG_SIZE(CW)) bus ();

    pixel_combinator #(
        .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RBG_SIZE(CW),
        .X_SIZE(XS), .Y_SIZE(YS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy_o        (busy),
        .multi_match_o (multi_match),
        .timeout_o     (timeout),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called in a SEEK cycle: present one match, check the OUT cycle, optionally complete the handshake.
    task automatic pixel(input int ex, input int ey, input logic [NQ-1:0] m,
                         input logic [NQ*CW-1:0] cols, input logic [NQ-1:0] exp_pop,
                         input logic [CW-1:0] exp_col, input logic exp_mm, input logic accept);
        check("seek_valid", 32'(bus.valid_o), 32'd0);
        check("xcheck", 32'(bus.xpixel_check_o), 32'(ex));
        check("ycheck", 32'(bus.ypixel_check_o), 32'(ey));
        bus.match_i  = m;
        bus.colour_i = cols;
        tick();
        bus.match_i = '0;
        check("pop", 32'(bus.pop_o), 32'(exp_pop));
        check("valid", 32'(bus.valid_o), 32'd1);
        check("colour", 32'(bus.colour_o), 32'(exp_col));
        check("multi", 32'(multi_match), 32'(exp_mm));
        check("sof", 32'(bus.sof_o), 32'((ex == 0) && (ey == 0)));
        check("eol", 32'(bus.eol_o), 32'(ex == XS - 1));
        bus.ready_i = accept;
        if (accept) begin
            tick();
            check("pop_once", 32'(bus.pop_o), 32'd0);
            check("multi_once", 32'(multi_match), 32'd0);
        end
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
    endtask

    initial begin
        logic [NQ*CW-1:0] cols;
        logic [CW-1:0]    base;
        int               q;

        reset = 1'b1;
        start = 1'b0;
        bus.match_i  = '0;
        bus.colour_i = '0;
        bus.ready_i  = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_pop", 32'(bus.pop_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_colour", 32'(bus.colour_o), 32'd0);
        check("rst_multi", 32'(multi_match), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_x", 32'(bus.xpixel_check_o), 32'd0);
        check("rst_y", 32'(bus.ypixel_check_o), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 1: queue 2 at (0,0), held off by backpressure for 10 cycles.
        begin_frame();
        pixel(0, 0, 4'b0100, {24'h0, 24'hFF0000, 24'h0, 24'h0}, 4'b0100, 24'hFF0000, 1'b0, 1'b0);
        bus.colour_i = {4{24'hABCDEF}};
        bus.match_i  = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(bus.valid_o), 32'd1);
            check("bp_colour", 32'(bus.colour_o), 32'hFF0000);
            check("bp_pop", 32'(bus.pop_o), 32'd0);
            check("bp_x", 32'(bus.xpixel_check_o), 32'd0);
        end
        bus.match_i = '0;
        bus.ready_i = 1'b1;
        tick();
        check("adv_valid", 32'(bus.valid_o), 32'd0);
        check("adv_x", 32'(bus.xpixel_check_o), 32'd1);

        // Tie between queues 1 and 3: queue 1 wins, queue 3 untouched.
        pixel(1, 0, 4'b1010, {24'h123456, 24'h0, 24'h00AA55, 24'h0}, 4'b0010, 24'h00AA55, 1'b1, 1'b1);
        for (int p = 2; p < XS * YS; p++) begin
            base = 24'h100000 + CW'(p);
            pixel(p % XS, p / XS, 4'b0001, {72'h0, base}, 4'b0001, base, 1'b0, 1'b1);
        end
        check("f1_idle", 32'(busy), 32'd0);
        check("f1_valid", 32'(bus.valid_o), 32'd0);

        // Frame 2: rotate the matching queue, each queue carries a distinct colour.
        begin_frame();
        for (int p = 0; p < XS * YS; p++) begin
            q    = p % NQ;
            base = 24'hC00000 + CW'(p << 4);
            cols = {base + 24'd3, base + 24'd2, base + 24'd1, base};
            pixel(p % XS, p / XS, NQ'(1 << q), cols, NQ'(1 << q), base + CW'(q), 1'b0, 1'b1);
        end
        check("f2_idle", 32'(busy), 32'd0);
        check("f2_x", 32'(bus.xpixel_check_o), 32'd0);
        check("f2_y", 32'(bus.ypixel_check_o), 32'd0);

        // Frame 3: reset while stalled in OUT at (2,1).
        begin_frame();
        for (int p = 0; p < 6; p++)
            pixel(p % XS, p / XS, 4'b1000, {24'h5A5A5A, 72'h0}, 4'b1000, 24'h5A5A5A, 1'b0, 1'b1);
        pixel(2, 1, 4'b0001, {72'h0, 24'h777777}, 4'b0001, 24'h777777, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ready_i = 1'b1;
        check("mid_valid", 32'(bus.valid_o), 32'd0);
        check("mid_pop", 32'(bus.pop_o), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_x", 32'(bus.xpixel_check_o), 32'd0);
        check("mid_y", 32'(bus.ypixel_check_o), 32'd0);
        check("mid_colour", 32'(bus.colour_o), 32'd0);
        begin_frame();
        pixel(0, 0, 4'b0010, {24'h0, 24'h0, 24'h00FF00, 24'h0}, 4'b0010, 24'h00FF00, 1'b0, 1'b1);

        // Starved SEEK at (1,0) for 8 cycles.
        bus.match_i  = '0;
        bus.colour_i = {4{24'hFFFFFF}};
        repeat (7) tick();
        check("to_wait_valid", 32'(bus.valid_o), 32'd0);
        tick();
`ifdef COMBINATOR_TIMEOUT_EN
        check("to_valid", 32'(bus.valid_o), 32'd1);
        check("to_colour", 32'(bus.colour_o), 32'd0);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_pop", 32'(bus.pop_o), 32'd0);
        check("to_x", 32'(bus.xpixel_check_o), 32'd1);
`else
        check("to_valid", 32'(bus.valid_o), 32'd0);
        check("to_flag", 32'(timeout), 32'd0);
        check("to_pop", 32'(bus.pop_o), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
